// File: rtl/dcache_top_pkg.sv
// Shared memory-stage definitions: cache geometry, request/write-back records and FSM states.
package dcache_top_pkg;

  localparam int unsigned ADDR_WIDTH          = 32;
  localparam int unsigned PC_WIDTH            = 32;
  localparam int unsigned REG_FILE_DATA_WIDTH = 32;
  localparam int unsigned REG_FILE_ADDR_WIDTH = 5;

  localparam int unsigned DCACHE_NUM_LINES    = 4;
  localparam int unsigned DCACHE_LINE_WIDTH   = 128;
  localparam int unsigned DCACHE_LINE_BYTES   = DCACHE_LINE_WIDTH / 8;
  localparam int unsigned DCACHE_OFFSET_WIDTH = $clog2(DCACHE_LINE_BYTES);
  localparam int unsigned DCACHE_INDEX_WIDTH  = $clog2(DCACHE_NUM_LINES);
  localparam int unsigned DCACHE_TAG_WIDTH    = ADDR_WIDTH - DCACHE_INDEX_WIDTH - DCACHE_OFFSET_WIDTH;

  typedef enum logic {
    BYTE = 1'b0,
    WORD = 1'b1
  } mem_size_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]          addr;
    mem_size_t                      size;
    logic                           is_store;
    logic [REG_FILE_DATA_WIDTH-1:0] data;
  } dcache_request_t;

  typedef enum logic [2:0] {
    IDLE,
    EVICT_REQ,
    EVICT_WAIT,
    FILL_REQ,
    FILL_WAIT,
    REPLAY
  } dcache_state_t;

  typedef struct packed {
    logic                           valid;
    logic                           rf_we;
    logic [REG_FILE_DATA_WIDTH-1:0] data;
    logic [REG_FILE_ADDR_WIDTH-1:0] dst_reg;
    logic [PC_WIDTH-1:0]            pc;
  } wb_request_t;

endpackage

// File: rtl/dcache_tag_data_array.sv
// Direct-mapped tag/valid/dirty/line storage: asynchronous read by index,
// one write port doing either a full-line fill or a byte-enabled merge.
module dcache_tag_data_array #(
  parameter int unsigned NUM_LINES  = 4,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned TAG_WIDTH  = 26,
  localparam int unsigned IDX_W     = $clog2(NUM_LINES),
  localparam int unsigned BYTES     = LINE_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [IDX_W-1:0]      rd_index,
  output logic [TAG_WIDTH-1:0]  rd_tag,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [LINE_WIDTH-1:0] rd_line,
  input  logic                  wr_fill,
  input  logic                  wr_merge,
  input  logic [IDX_W-1:0]      wr_index,
  input  logic [TAG_WIDTH-1:0]  wr_tag,
  input  logic [LINE_WIDTH-1:0] wr_line,
  input  logic [BYTES-1:0]      wr_byte_en
);

  logic [TAG_WIDTH-1:0]  tag_q  [NUM_LINES];
  logic [LINE_WIDTH-1:0] line_q [NUM_LINES];
  logic [NUM_LINES-1:0]  valid_q;
  logic [NUM_LINES-1:0]  dirty_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_fill) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= 1'b0;
    end else if (wr_merge) begin
      dirty_q[wr_index] <= 1'b1;
    end
  end

  // Tags and line data carry no reset; valid bits gate every use.
  always_ff @(posedge clock) begin
    if (wr_fill) begin
      tag_q[wr_index]  <= wr_tag;
      line_q[wr_index] <= wr_line;
    end else if (wr_merge) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (wr_byte_en[b]) line_q[wr_index][b*8 +: 8] <= wr_line[b*8 +: 8];
      end
    end
  end

  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = line_q[rd_index];
  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];

endmodule

// File: rtl/dcache_top.sv
// Memory stage: write-back/write-allocate direct-mapped data cache for M-type
// requests, flop-through of R-type results, ALU stall and RF bypass.
module dcache_top
  import dcache_top_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           req_dcache_valid,
  input  dcache_request_t                req_dcache_info,
  input  logic [PC_WIDTH-1:0]            req_dcache_pc,
  input  logic                           req_m_type_instr,
  input  logic                           req_r_type_instr,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] req_dst_reg,
  output logic                           dcache_stall,
  output logic                           req_wb_valid,
  output logic                           req_wb_rf_we,
  output logic [REG_FILE_DATA_WIDTH-1:0] req_wb_data,
  output logic [REG_FILE_ADDR_WIDTH-1:0] req_wb_dst_reg,
  output logic [PC_WIDTH-1:0]            req_wb_pc,
  output logic                           xcpt_dcache_misaligned,
  output logic [REG_FILE_DATA_WIDTH-1:0] cache_data_bypass,
  output logic                           cache_data_bp_valid,
  output logic                           mem_req_valid,
  output logic                           mem_req_is_write,
  output logic [ADDR_WIDTH-1:0]          mem_req_addr,
  output logic [DCACHE_LINE_WIDTH-1:0]   mem_req_data,
  input  logic                           mem_rsp_valid,
  input  logic [DCACHE_LINE_WIDTH-1:0]   mem_rsp_data
);

  dcache_state_t state_q, state_d;
  wb_request_t   wb_q;
  logic          xcpt_q;

  logic [DCACHE_OFFSET_WIDTH-1:0] offset;
  logic [DCACHE_INDEX_WIDTH-1:0]  index;
  logic [DCACHE_TAG_WIDTH-1:0]    tag;
  logic [DCACHE_TAG_WIDTH-1:0]    rd_tag;
  logic [DCACHE_LINE_WIDTH-1:0]   rd_line;
  logic                           rd_valid, rd_dirty;
  logic                           misaligned, m_access, hit, accept;
  logic                           wr_fill, wr_merge;
  logic [DCACHE_LINE_WIDTH-1:0]   wr_line;
  logic [DCACHE_LINE_BYTES-1:0]   wr_byte_en;
  logic [REG_FILE_DATA_WIDTH-1:0] load_data;

  assign offset     = req_dcache_info.addr[DCACHE_OFFSET_WIDTH-1:0];
  assign index      = req_dcache_info.addr[DCACHE_OFFSET_WIDTH +: DCACHE_INDEX_WIDTH];
  assign tag        = req_dcache_info.addr[ADDR_WIDTH-1 -: DCACHE_TAG_WIDTH];
  assign misaligned = (req_dcache_info.size == WORD) && (offset[1:0] != 2'b00);
  assign m_access   = req_dcache_valid && req_m_type_instr && !misaligned;
  assign hit        = rd_valid && (rd_tag == tag);

  assign load_data = (req_dcache_info.size == WORD)
                   ? rd_line[{offset[3:2], 5'd0} +: 32]
                   : {24'd0, rd_line[{offset, 3'd0} +: 8]};

  dcache_tag_data_array #(
    .NUM_LINES  (DCACHE_NUM_LINES),
    .LINE_WIDTH (DCACHE_LINE_WIDTH),
    .TAG_WIDTH  (DCACHE_TAG_WIDTH)
  ) u_array (
    .clock      (clock),
    .reset      (reset),
    .rd_index   (index),
    .rd_tag     (rd_tag),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_line    (rd_line),
    .wr_fill    (wr_fill),
    .wr_merge   (wr_merge),
    .wr_index   (index),
    .wr_tag     (tag),
    .wr_line    (wr_line),
    .wr_byte_en (wr_byte_en)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // REPLAY shares the IDLE lookup path: the just-filled line makes it a hit.
  always_comb begin
    state_d          = state_q;
    dcache_stall     = 1'b0;
    accept           = 1'b0;
    mem_req_valid    = 1'b0;
    mem_req_is_write = 1'b0;
    mem_req_addr     = '0;
    mem_req_data     = '0;
    wr_fill          = 1'b0;
    wr_merge         = 1'b0;
    wr_line          = '0;
    wr_byte_en       = '0;
    case (state_q)
      IDLE, REPLAY: begin
        state_d = IDLE;
        if (m_access && !hit) begin
          dcache_stall = 1'b1;
          state_d      = (rd_valid && rd_dirty) ? EVICT_REQ : FILL_REQ;
        end else begin
          accept = req_dcache_valid;
          if (m_access && req_dcache_info.is_store) begin
            wr_merge = 1'b1;
            if (req_dcache_info.size == WORD) begin
              wr_line    = {(DCACHE_LINE_WIDTH/32){req_dcache_info.data}};
              wr_byte_en = DCACHE_LINE_BYTES'(4'hF) << {offset[3:2], 2'b00};
            end else begin
              wr_line    = {DCACHE_LINE_BYTES{req_dcache_info.data[7:0]}};
              wr_byte_en = DCACHE_LINE_BYTES'(1) << offset;
            end
          end
        end
      end
      EVICT_REQ: begin
        dcache_stall     = 1'b1;
        mem_req_valid    = 1'b1;
        mem_req_is_write = 1'b1;
        mem_req_addr     = {rd_tag, index, {DCACHE_OFFSET_WIDTH{1'b0}}};
        mem_req_data     = rd_line;
        state_d          = EVICT_WAIT;
      end
      EVICT_WAIT: begin
        dcache_stall = 1'b1;
        if (mem_rsp_valid) state_d = FILL_REQ;
      end
      FILL_REQ: begin
        dcache_stall  = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_dcache_info.addr[ADDR_WIDTH-1:DCACHE_OFFSET_WIDTH],
                         {DCACHE_OFFSET_WIDTH{1'b0}}};
        state_d       = FILL_WAIT;
      end
      FILL_WAIT: begin
        dcache_stall = 1'b1;
        if (mem_rsp_valid) begin
          wr_fill = 1'b1;
          wr_line = mem_rsp_data;
          state_d = REPLAY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_q   <= '0;
      xcpt_q <= 1'b0;
    end else if (accept) begin
      wb_q.valid   <= 1'b1;
      wb_q.rf_we   <= req_m_type_instr ? (!misaligned && !req_dcache_info.is_store)
                                       : req_r_type_instr;
      wb_q.data    <= (m_access && !req_dcache_info.is_store) ? load_data
                                                              : req_dcache_info.data;
      wb_q.dst_reg <= req_dst_reg;
      wb_q.pc      <= req_dcache_pc;
      xcpt_q       <= req_m_type_instr && misaligned;
    end else begin
      wb_q.valid <= 1'b0;
      xcpt_q     <= 1'b0;
    end
  end

  assign req_wb_valid           = wb_q.valid;
  assign req_wb_rf_we           = wb_q.rf_we;
  assign req_wb_data            = wb_q.data;
  assign req_wb_dst_reg         = wb_q.dst_reg;
  assign req_wb_pc              = wb_q.pc;
  assign xcpt_dcache_misaligned = xcpt_q;
  assign cache_data_bypass      = wb_q.data;
  assign cache_data_bp_valid    = wb_q.valid && wb_q.rf_we;

endmodule
